// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package imem_loader_pkg;

  localparam int unsigned IMEM_ADDR_W = 8;
  localparam int unsigned IMEM_DATA_W = 32;

  // Filler instruction used to pad programs.
  localparam logic [31:0] INSTR_NOP = 32'h0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_ERROR
  } state_e;

endpackage

// File: rtl/imem_loader_write_reg.sv
// Registered instruction memory write port: one pipeline stage holding
// address, data and strobe, cleared asynchronously by the active-low reset.
module imem_write_reg #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wr_data_o
);

  logic              wr_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // Strobe is a one-cycle echo of the accept; address/data hold between writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      wr_en_q <= wr_en_i;
      if (wr_en_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end

  assign mem_wr_en_o   = wr_en_q;
  assign mem_addr_o    = addr_q;
  assign mem_wr_data_o = data_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: streams words into consecutive
// addresses from 0 and holds the core in reset until the last write commits.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a running Checksum port.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = IMEM_DATA_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [DATA_W-1:0] InWord,
  input  logic              InValid,
  input  logic              InLast,
  output logic              InReady,
  output logic              MemWrEn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWrData,
  output logic              CoreRst,
  output logic              Done,
  output logic              Error,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [DATA_W-1:0] Checksum,
`endif
  output logic [ADDR_W:0]   WordCount
);

  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              in_ready_q;
  logic              core_rst_q;
  logic              done_q;
  logic              error_q;
  logic              accept;
  logic              addr_at_top;

  assign accept      = InValid && in_ready_q;
  assign addr_at_top = (addr_q == '1);

  // Next address/count: the address never wraps and the count saturates.
  always_comb begin
    addr_d  = addr_at_top ? addr_q : addr_q + ADDR_W'(1);
    count_d = (count_q == COUNT_MAX) ? count_q : count_q + (ADDR_W+1)'(1);
  end

  // Load sequencer; status outputs are registered alongside each transition.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_RUN, S_ERROR: begin
          if (Start) begin
            state_q    <= S_LOAD;
            addr_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            addr_q  <= addr_d;
            count_q <= count_d;
            if (InLast) begin
              state_q    <= S_FLUSH;
              in_ready_q <= 1'b0;
            end else if (addr_at_top) begin
              state_q    <= S_ERROR;
              in_ready_q <= 1'b0;
              error_q    <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          state_q    <= S_RUN;
          core_rst_q <= 1'b0;
          done_q     <= 1'b1;
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          core_rst_q <= 1'b1;
          done_q     <= 1'b0;
          error_q    <= 1'b0;
        end
      endcase
    end
  end

  imem_write_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_write_reg (
    .clk_i         (Clk),
    .rst_ni        (Rst),
    .wr_en_i       (accept),
    .addr_i        (addr_q),
    .data_i        (InWord),
    .mem_wr_en_o   (MemWrEn),
    .mem_addr_o    (MemAddr),
    .mem_wr_data_o (MemWrData)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // Running modular sum of accepted words, restarted with each load.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sum_q <= '0;
    end else if ((state_q != S_LOAD) && Start) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + InWord;
    end
  end

  assign Checksum = sum_q;
`endif

  assign InReady   = in_ready_q;
  assign CoreRst   = core_rst_q;
  assign Done      = done_q;
  assign Error     = error_q;
  assign WordCount = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a full-size instance for nominal, stall,
// restart and reset cases, and a 4-word instance for overflow.
module tb_imem_loader;

  typedef struct {
    logic [31:0] data;
    int unsigned addr;
    int          cyc;
  } wr_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- main instance (ADDR_W=8) ----------------
  logic        Rst = 1'b0, Start = 1'b0, InValid = 1'b0, InLast = 1'b0;
  logic [31:0] InWord = '0;
  logic        InReady, MemWrEn, CoreRst, Done, Error;
  logic [7:0]  MemAddr;
  logic [31:0] MemWrData;
  logic [8:0]  WordCount;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] Checksum;
`endif

  imem_loader #(.ADDR_W(8), .DATA_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .InWord(InWord), .InValid(InValid),
    .InLast(InLast), .InReady(InReady), .MemWrEn(MemWrEn), .MemAddr(MemAddr),
    .MemWrData(MemWrData), .CoreRst(CoreRst), .Done(Done), .Error(Error),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .Checksum(Checksum),
`endif
    .WordCount(WordCount)
  );

  // ---------------- overflow instance (ADDR_W=2) ----------------
  logic        ov_Rst = 1'b0, ov_Start = 1'b0, ov_InValid = 1'b0, ov_InLast = 1'b0;
  logic [31:0] ov_InWord = '0;
  logic        ov_InReady, ov_MemWrEn, ov_CoreRst, ov_Done, ov_Error;
  logic [1:0]  ov_MemAddr;
  logic [31:0] ov_MemWrData;
  logic [2:0]  ov_WordCount;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] ov_Checksum;
`endif

  imem_loader #(.ADDR_W(2), .DATA_W(32)) dut_ov (
    .Clk(Clk), .Rst(ov_Rst), .Start(ov_Start), .InWord(ov_InWord), .InValid(ov_InValid),
    .InLast(ov_InLast), .InReady(ov_InReady), .MemWrEn(ov_MemWrEn), .MemAddr(ov_MemAddr),
    .MemWrData(ov_MemWrData), .CoreRst(ov_CoreRst), .Done(ov_Done), .Error(ov_Error),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .Checksum(ov_Checksum),
`endif
    .WordCount(ov_WordCount)
  );

  // ---------------- scoreboards ----------------
  wr_t q_main[$];
  wr_t q_ov[$];
  int unsigned addr_exp = 0;
  int unsigned ov_addr_exp = 0;

  always @(negedge Clk) begin
    if (MemWrEn === 1'b1) begin
      if (q_main.size() == 0) begin
        check("main_unexpected_write", 64'(MemAddr), 64'hFFFF);
      end else begin
        wr_t e;
        e = q_main.pop_front();
        check("main_wr_addr", 64'(MemAddr), 64'(e.addr));
        check("main_wr_data", 64'(MemWrData), 64'(e.data));
        check("main_wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge Clk) begin
    if (ov_MemWrEn === 1'b1) begin
      if (q_ov.size() == 0) begin
        check("ov_unexpected_write", 64'(ov_MemAddr), 64'hFFFF);
      end else begin
        wr_t e;
        e = q_ov.pop_front();
        check("ov_wr_addr", 64'(ov_MemAddr), 64'(e.addr));
        check("ov_wr_data", 64'(ov_MemWrData), 64'(e.data));
        check("ov_wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_main();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    addr_exp = 0;
  endtask

  task automatic send_main(input logic [31:0] w, input logic last);
    wr_t e;
    check("main_inready_before_accept", 64'(InReady), 64'd1);
    InValid = 1'b1;
    InWord  = w;
    InLast  = last;
    e.data = w;
    e.addr = addr_exp;
    e.cyc  = cyc + 1;
    q_main.push_back(e);
    addr_exp++;
    tick();
    InValid = 1'b0;
    InLast  = 1'b0;
  endtask

  task automatic send_ov(input logic [31:0] w, input logic last);
    wr_t e;
    check("ov_inready_before_accept", 64'(ov_InReady), 64'd1);
    ov_InValid = 1'b1;
    ov_InWord  = w;
    ov_InLast  = last;
    e.data = w;
    e.addr = ov_addr_exp;
    e.cyc  = cyc + 1;
    q_ov.push_back(e);
    ov_addr_exp++;
    tick();
    ov_InValid = 1'b0;
    ov_InLast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset held for 2 cycles
    tick();
    tick();
    check("rst_coreRst", 64'(CoreRst), 64'd1);
    check("rst_inReady", 64'(InReady), 64'd0);
    check("rst_memWrEn", 64'(MemWrEn), 64'd0);
    check("rst_memAddr", 64'(MemAddr), 64'd0);
    check("rst_memWrData", 64'(MemWrData), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_error", 64'(Error), 64'd0);
    check("rst_wordCount", 64'(WordCount), 64'd0);
    Rst = 1'b1;
    ov_Rst = 1'b1;

    // Idle with no Start: nothing happens
    repeat (3) tick();
    check("idle_coreRst", 64'(CoreRst), 64'd1);
    check("idle_inReady", 64'(InReady), 64'd0);
    check("idle_done", 64'(Done), 64'd0);

    // Nominal 4-word back-to-back load
    start_main();
    check("load_wordCount_cleared", 64'(WordCount), 64'd0);
    send_main(32'h20010005, 1'b0);
    send_main(32'h20020003, 1'b0);
    send_main(32'h00221820, 1'b0);
    send_main(32'hAC030000, 1'b1);
    // FLUSH cycle: last write visible, core still held
    check("flush_coreRst", 64'(CoreRst), 64'd1);
    check("flush_done", 64'(Done), 64'd0);
    check("flush_inReady", 64'(InReady), 64'd0);
    tick();
    check("nom_coreRst_released", 64'(CoreRst), 64'd0);
    check("nom_done", 64'(Done), 64'd1);
    check("nom_error", 64'(Error), 64'd0);
    check("nom_wordCount", 64'(WordCount), 64'd4);
    tick();
    check("nom_run_wordCount_held", 64'(WordCount), 64'd4);

    // Stalled source: valid pattern 1,0,0,1,1 with last on 3rd valid
    start_main();
    check("restart_coreRst", 64'(CoreRst), 64'd1);
    check("restart_done", 64'(Done), 64'd0);
    send_main(32'h11111111, 1'b0);
    tick();
    tick();
    send_main(32'h22222222, 1'b0);
    send_main(32'h33333333, 1'b1);
    tick();
    check("stall_done", 64'(Done), 64'd1);
    check("stall_wordCount", 64'(WordCount), 64'd3);

    // Reset between 2nd and 3rd accept, with 2nd write in flight
    start_main();
    send_main(32'hA0000001, 1'b0);
    send_main(32'hA0000002, 1'b0);
    Rst = 1'b0;
    void'(q_main.pop_back());
    #1;
    check("midrst_memWrEn", 64'(MemWrEn), 64'd0);
    check("midrst_coreRst", 64'(CoreRst), 64'd1);
    check("midrst_wordCount", 64'(WordCount), 64'd0);
    check("midrst_inReady", 64'(InReady), 64'd0);
    check("midrst_memAddr", 64'(MemAddr), 64'd0);
    tick();
    Rst = 1'b1;
    tick();
    start_main();
    send_main(32'hB0000000, 1'b0);
    send_main(32'hB0000001, 1'b0);
    send_main(32'hB0000002, 1'b1);
    tick();
    check("reload_done", 64'(Done), 64'd1);
    check("reload_wordCount", 64'(WordCount), 64'd3);

    // Single-word program
    start_main();
    send_main(32'hC0FFEE00, 1'b1);
    tick();
    check("single_done", 64'(Done), 64'd1);
    check("single_wordCount", 64'(WordCount), 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    start_main();
    check("csum_cleared", 64'(Checksum), 64'd0);
    send_main(32'hFFFFFFFF, 1'b0);
    send_main(32'h00000002, 1'b1);
    tick();
    check("csum_run_done", 64'(Done), 64'd1);
    check("csum_value", 64'(Checksum), 64'h00000001);
`endif

    // Overflow on the 4-word instance: 5 words, none last
    ov_Start = 1'b1;
    tick();
    ov_Start = 1'b0;
    ov_addr_exp = 0;
    send_ov(32'hD0000000, 1'b0);
    send_ov(32'hD0000001, 1'b0);
    send_ov(32'hD0000002, 1'b0);
    send_ov(32'hD0000003, 1'b0);
    check("ov_error", 64'(ov_Error), 64'd1);
    check("ov_inReady", 64'(ov_InReady), 64'd0);
    check("ov_coreRst", 64'(ov_CoreRst), 64'd1);
    check("ov_done", 64'(ov_Done), 64'd0);
    check("ov_wordCount", 64'(ov_WordCount), 64'd4);
    ov_InValid = 1'b1;
    ov_InWord  = 32'hD0000004;
    for (int i = 0; i < 3; i++) begin
      check("ov_5th_not_ready", 64'(ov_InReady), 64'd0);
      tick();
    end
    ov_InValid = 1'b0;
    check("ov_error_held", 64'(ov_Error), 64'd1);
    check("ov_wordCount_held", 64'(ov_WordCount), 64'd4);
    check("ov_coreRst_held", 64'(ov_CoreRst), 64'd1);
    ov_Start = 1'b1;
    tick();
    ov_Start = 1'b0;
    ov_addr_exp = 0;
    check("ov_restart_error_clr", 64'(ov_Error), 64'd0);
    check("ov_restart_wordCount_clr", 64'(ov_WordCount), 64'd0);
    check("ov_restart_inReady", 64'(ov_InReady), 64'd1);
    send_ov(32'hE0000000, 1'b1);
    tick();
    check("ov_reload_done", 64'(ov_Done), 64'd1);
    check("ov_reload_wordCount", 64'(ov_WordCount), 64'd1);

    repeat (2) tick();
    check("main_queue_drained", 64'(q_main.size()), 64'd0);
    check("ov_queue_drained", 64'(q_ov.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction memory writer for the pipelined SAD datapath. Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive instruction memory addresses from 0. Holds the core in reset while loading and releases it only after the last write has committed. Sits between the bench/host side and the instruction memory write port. It is the writer whose contents the fetch stage reads and whose `Instruction` output the top-level bench observes.

## Interface
- `ADDR_W`, 8, instruction memory word-address width; depth = 2^ADDR_W words
- `DATA_W`, 32, instruction word width
- `Clk` in 1: single clock; all state updates on the rising edge
- `Rst` in 1: asynchronous, active-low reset
- `Start` in 1: begin or restart a load; single-cycle pulse
- `InWord` in DATA_W: instruction word
- `InValid` in 1: `InWord` and `InLast` are valid
- `InLast` in 1: marks the final word of the program
- `InReady` out 1: loader accepts a word this cycle
- `MemWrEn` out 1: instruction memory write strobe
- `MemAddr` out ADDR_W: write word address
- `MemWrData` out DATA_W: write data
- `CoreRst` out 1: active-high reset to the datapath
- `Done` out 1: program loaded, core running
- `Error` out 1: program overflowed the memory depth
- `WordCount` out ADDR_W+1: number of words written in the current load

## Operation
- FSM states: IDLE, LOAD, FLUSH, RUN, ERROR. Reset state is IDLE.
- IDLE, RUN, ERROR:
  - `Start`=1 → LOAD.
  - On that transition, the address counter and `WordCount` clear to 0.
- LOAD:
  - `InReady`=1.
  - A word is accepted on a cycle with `InValid`&&`InReady`.
  - An accepted word is registered to `MemWrData`/`MemAddr` with `MemWrEn`=1 on the next cycle.
  - After each accept, the address increments and `WordCount` increments.
  - Accepted word with `InLast`=1 → FLUSH.
  - Accepted word without `InLast` at address 2^ADDR_W−1 → ERROR. That word is still written. No address wrap-around ever occurs.
  - `Start` in LOAD is ignored.
- FLUSH: lasts one cycle; the final write commits. Then → RUN.
- RUN: `CoreRst`=0, `Done`=1.
- ERROR: `Error`=1, `CoreRst`=1, `InReady`=0. Left only via `Start` or `Rst`.
- `InReady`=0 in every state except LOAD. `InWord` is ignored when `InReady`=0.
- `CoreRst`=1 in every state except RUN. Restarting a load from RUN re-asserts `CoreRst` on the cycle after `Start`.
- `Error` and `Done` are registered state decodes. They are mutually exclusive.
- `WordCount` saturates at 2^ADDR_W and is held through RUN/ERROR until the next `Start`.

## Timing
- Reset values:
  - State = IDLE
  - `InReady`=0, `MemWrEn`=0, `MemAddr`=0, `MemWrData`=0
  - `CoreRst`=1, `Done`=0, `Error`=0, `WordCount`=0
- Write latency: a word accepted at edge N appears on `MemWrEn`/`MemAddr`/`MemWrData` in cycle N+1, for exactly one cycle per accepted word.
- Throughput: one word per cycle. Back-to-back accepts produce consecutive write cycles.
- Release: if `InLast` is accepted at edge N, the final write occurs in cycle N+1 (FLUSH), and `CoreRst` falls with `Done` rising at cycle N+2.
- A single-word program (first word has `InLast`=1) is legal and writes address 0 only.
- `Rst` asserted mid-load: all outputs return to reset values immediately (asynchronously). An in-flight `MemWrEn` is dropped. Memory contents are not cleared.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - Adds output `Checksum` (DATA_W): running sum mod 2^DATA_W of accepted words.
  - Cleared on reset and on `Start`; updated on the accept edge.
  - Final value is stable in RUN/ERROR.
- Not defined: the `Checksum` port and its adder are absent. All other behaviour is identical.

## Structure
- Shared package `imem_loader_pkg` holds:
  - The state enum (IDLE, LOAD, FLUSH, RUN, ERROR)
  - Default `ADDR_W`/`DATA_W` constants
  - The `INSTR_NOP` constant (32'h0) used by benches to pad programs
- One natural sub-module: `imem_write_reg`, the registered write port (address/data/strobe pipeline register with async active-low clear). The FSM and counters stay in the top module.

## Test plan
- Reset then idle: hold `Rst`=0 for 2 cycles, release with no `Start` → `CoreRst`=1, `InReady`=0, `MemWrEn` never asserts.
- Nominal load: pulse `Start`, stream 4 words 32'h20010005, 32'h20020003, 32'h00221820, 32'hAC030000 back-to-back, `InLast` on the 4th:
  - Writes go to addresses 0..3 on the cycles following each accept.
  - `WordCount`=4.
  - `CoreRst` falls 2 cycles after the last accept.
- Stalled source: toggle `InValid` 1,0,0,1,1 with `InLast` on the 3rd valid → exactly 3 writes at addresses 0,1,2 with no gaps in addresses; `Done`=1.
- Overflow with `ADDR_W`=2: stream 5 words, none marked last:
  - 4 writes occur, then `Error`=1 and `InReady`=0.
  - The 5th word is never accepted; `CoreRst` stays 1.
  - A later `Start` clears `Error` and `WordCount`.
- Reset mid-load: assert `Rst` between the 2nd and 3rd accept → `MemWrEn`/`CoreRst`/`WordCount` take reset values asynchronously; a fresh `Start` reloads from address 0.
- Checksum (macro defined): load 32'hFFFFFFFF, 32'h00000002 → `Checksum`=32'h00000001 in RUN.
